// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver, 8 data bits, 1 stop bit.
// Define UART_RX_PARITY_EN for a trailing even-parity bit (8E1).
module uart_receiver #(
    parameter int OVS_DIV = 326
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] d_out,
    output logic       rx_valid,
    output logic       rx_status,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DW = (OVS_DIV > 2) ? $clog2(OVS_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(OVS_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

    state_t          state, state_n;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [DW-1:0]   div_cnt, div_n;
    logic            tick;
    logic [3:0]      tick_cnt, tick_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shreg, sh_n;
    logic [7:0]      dout_n;
    logic            valid_n;
    logic            ferr_n;

    assign rx_s = sync_q[1];
    assign tick = (div_cnt == DIV_MAX);

    // Busy drops in the cycle a result pulses, even when BRK follows.
    assign rx_status = (state != IDLE) && !frame_err;

`ifdef UART_RX_PARITY_EN
    logic par_bad, pbad_n;
    logic perr_n;
`endif

    always_comb begin
        state_n = state;
        div_n   = tick ? '0 : div_cnt + 1'b1;
        tick_n  = tick_cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        dout_n  = d_out;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_n  = par_bad;
        perr_n  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    div_n   = '0;
                    tick_n  = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd7) begin
                        tick_n  = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        sh_n  = {rx_s, shreg[7:1]};
                        bit_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        pbad_n  = rx_s ^ (^shreg);
                        state_n = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (rx_s) begin
                            dout_n  = shreg;
                            valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_n  = par_bad;
`endif
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BRK;
                        end
                    end
                end
            end
            BRK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state     <= IDLE;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            d_out     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            state     <= state_n;
            div_cnt   <= div_n;
            tick_cnt  <= tick_n;
            bit_idx   <= bit_n;
            shreg     <= sh_n;
            d_out     <= dout_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad    <= pbad_n;
            parity_err <= perr_n;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at OVS_DIV=4 (64 clk per bit).
// Scoreboard of expected bytes, popped on each rx_valid.
module tb_uart_receiver;

    localparam int OVS      = 4;
    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [7:0] d_out;
    logic       rx_valid;
    logic       rx_status;
    logic       frame_err;
    logic       parity_err;

    uart_receiver #(.OVS_DIV(OVS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .d_out      (d_out),
        .rx_valid   (rx_valid),
        .rx_status  (rx_status),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        int         gap;
        logic [7:0] exp_d;
    } vec_t;

    exp_t       sb[$];
    exp_t       got;
    vec_t       tbl[6];
    int         ferr_pend = 0;
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         edge_cyc = 0;
    int         valid_cyc = 0;
    int         lat;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic bitclks(logic v, int n);
        #1 rx_in = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(logic [7:0] d, logic stop_v, logic par_flip);
        #1 edge_cyc = cyc;
        bitclks(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            bitclks(d[i], BIT_CLKS);
            if (i == 0) begin
                #2 check("rx_status_busy", 32'(rx_status), 32'd1);
            end
        end
`ifdef UART_RX_PARITY_EN
        bitclks((^d) ^ par_flip, BIT_CLKS);
`else
        if (par_flip) $display("note: parity not compiled in");
`endif
        bitclks(stop_v, BIT_CLKS);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || ferr_pend != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("drain_sb", 32'(sb.size()), 32'd0);
        check("drain_ferr", 32'(ferr_pend), 32'd0);
        sb.delete();
        ferr_pend = 0;
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (rx_valid) begin
                valid_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_valid actual=1 required=0 d_out=%0h", d_out);
                end else begin
                    got = sb.pop_front();
                    check("d_out", 32'(d_out), 32'(got.d));
                    check("parity_err", 32'(parity_err), 32'(got.perr));
                    check("status_on_valid", 32'(rx_status), 32'd0);
                    check("valid_ferr_excl", 32'(frame_err), 32'd0);
                    last_good = got.d;
                end
            end else if (parity_err) begin
                checks++;
                errors++;
                $display("FAIL stray_parity_err actual=1 required=0");
            end
            if (frame_err) begin
                if (ferr_pend == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_err actual=1 required=0");
                end else begin
                    ferr_pend--;
                    check("d_out_on_ferr", 32'(d_out), 32'(last_good));
                    check("status_on_ferr", 32'(rx_status), 32'd0);
                end
            end
        end
    end

    initial begin
        tbl[0] = '{8'h00, 0,  8'h00};
        tbl[1] = '{8'hFF, 0,  8'hFF};
        tbl[2] = '{8'h55, 17, 8'h55};
        tbl[3] = '{8'hAA, 0,  8'hAA};
        tbl[4] = '{8'h01, 5,  8'h01};
        tbl[5] = '{8'h80, 40, 8'h80};

        rx_in = 1'b1;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_status", 32'(rx_status), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        @(posedge clk);
        bitclks(1'b1, 20);

        sb.push_back('{8'hA5, 1'b0});
        send_frame(8'hA5, 1'b1, 1'b0);
        lat = valid_cyc - edge_cyc;
        checks++;
        if (lat < 600 || lat > 620) begin
            errors++;
            $display("FAIL latency actual=%0d required=600..620", lat);
        end
        bitclks(1'b1, 30);
        drain();

        ferr_pend = 1;
        send_frame(8'h3C, 1'b0, 1'b0);
        bitclks(1'b0, 2 * BIT_CLKS);
        bitclks(1'b1, BIT_CLKS);
        drain();
        #2 check("d_out_kept", 32'(d_out), 32'hA5);
        sb.push_back('{8'h11, 1'b0});
        send_frame(8'h11, 1'b1, 1'b0);
        bitclks(1'b1, 30);
        drain();

        bitclks(1'b0, 3 * OVS);
        bitclks(1'b1, 20);
        #2 check("glitch_busy", 32'(rx_status), 32'd1);
        bitclks(1'b1, 60);
        #2 check("glitch_idle", 32'(rx_status), 32'd0);
        sb.push_back('{8'h5A, 1'b0});
        send_frame(8'h5A, 1'b1, 1'b0);
        bitclks(1'b1, 30);
        drain();

        bitclks(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) bitclks(1'b1, BIT_CLKS);
        bitclks(1'b1, 30);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        last_good = 8'h00;
        #2 check("mid_rst_d_out", 32'(d_out), 32'h0);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_status", 32'(rx_status), 32'd0);
        @(posedge clk);
        bitclks(1'b1, 6 * BIT_CLKS);
        sb.push_back('{8'h81, 1'b0});
        send_frame(8'h81, 1'b1, 1'b0);
        bitclks(1'b1, 30);
        drain();

        for (int i = 0; i < 6; i++) begin
            sb.push_back('{tbl[i].exp_d, 1'b0});
            send_frame(tbl[i].d, 1'b1, 1'b0);
            if (tbl[i].gap > 0) bitclks(1'b1, tbl[i].gap);
        end
        bitclks(1'b1, 30);
        drain();

`ifdef UART_RX_PARITY_EN
        sb.push_back('{8'h07, 1'b1});
        send_frame(8'h07, 1'b1, 1'b1);
        bitclks(1'b1, 30);
        drain();
        sb.push_back('{8'h07, 1'b0});
        send_frame(8'h07, 1'b1, 1'b0);
        bitclks(1'b1, 30);
        drain();
`endif

        bitclks(1'b1, 100);
        #2 check("final_idle", 32'(rx_status), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter OVS_DIV, default 326, clk cycles per 16x-oversample tick (50 MHz / 9600 baud / 16).
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port rx_in, input, 1, asynchronous serial line; idle is high.
REQ-005 SHALL have port d_out, output, 8, last correctly framed received byte.
REQ-006 SHALL have port rx_valid, output, 1, one-clk pulse marking a new byte on d_out.
REQ-007 SHALL have port rx_status, output, 1, receiver busy (high while a frame is in progress).
REQ-008 SHALL have port frame_err, output, 1, one-clk pulse when the stop bit is sampled low.
REQ-009 SHALL have port parity_err, output, 1, one-clk pulse on parity mismatch (see Configuration).

Function
REQ-010 SHALL pass rx_in through a 2-flop synchronizer before any use; the FSM sees only the synchronized rx_s.
REQ-011 SHALL generate a one-clk tick every OVS_DIV clks from a divider counter; the divider clears to 0 when a start edge is detected in IDLE.
REQ-012 SHALL use states IDLE, START, DATA, PARITY (macro only), STOP and BRK, with a 4-bit tick counter and a 3-bit bit index.
REQ-013 IDLE: on rx_s==0, go to START and clear the tick counter; otherwise remain in IDLE.
REQ-014 START: on the 8th tick (mid start bit), go to DATA if rx_s==0; if rx_s==1, treat it as a glitch and return to IDLE with no output pulse.
REQ-015 DATA: sample rx_s every 16th tick and shift it in LSB first; after bit index 7, go to PARITY if compiled in, else STOP.
REQ-016 STOP: sample rx_s on the 16th tick. If high, load d_out and pulse rx_valid in the next clk, then go to IDLE. If low, pulse frame_err, leave d_out unchanged and go to BRK.
REQ-017 BRK: remain until rx_s==1, then go to IDLE; no start detection occurs during BRK.
REQ-018 rx_status SHALL be high in every state except IDLE, and low in the same clk that rx_valid or frame_err pulses.
REQ-019 rx_valid, frame_err and parity_err SHALL each be exactly 1 clk wide; rx_valid and frame_err are mutually exclusive.
REQ-020 SHALL detect a start bit arriving immediately after the stop sample (zero idle gap); back-to-back frames are supported.
REQ-021 d_out SHALL hold its value until the next successful frame.

Reset
REQ-022 On rst high at a clk edge: state=IDLE, d_out=0x00, and rx_valid, frame_err, parity_err, rx_status, counters and shift register all =0.
REQ-023 Synchronizer flops SHALL reset to 1 so that reset release never causes a false start.
REQ-024 Reset mid-frame SHALL discard partial data and generate no pulse; rst overrides all other events in the same clk.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: an even-parity bit follows the data bits and is sampled on the 16th tick in PARITY.
REQ-026 With the macro defined, a mismatch pulses parity_err in the same clk as rx_valid, and d_out is still updated.
REQ-027 Macro undefined: the frame is 8N1 (10 bits), PARITY state does not exist, and parity_err is tied to 0.

Verification (OVS_DIV=4, 64 clk per bit)
REQ-028 8N1 frame 0xA5 -> d_out=0xA5, one rx_valid pulse about 9.5 bit times after the start edge, rx_status high throughout the frame.
REQ-029 rx_in low for 3 ticks then high -> no rx_valid, no frame_err, FSM back in IDLE, next frame 0x5A received correctly.
REQ-030 Frame 0x3C with stop bit low, line held low 2 bit times -> frame_err pulse, d_out keeps previous 0xA5, then 0x11 received after the line returns high.
REQ-031 rst pulsed during data bit 4, then frame 0x81 -> outputs cleared to 0, single rx_valid with d_out=0x81.
REQ-032 Frames 0x00 and 0xFF back-to-back with zero gap -> two rx_valid pulses, d_out=0x00 then 0xFF.
REQ-033 With UART_RX_PARITY_EN, frame 0x07 sent with parity bit 0 -> rx_valid and parity_err in the same clk, d_out=0x07; the same frame with parity bit 1 -> no parity_err.
